// File: rtl/write_queue_tx_pkg.sv
// Shared definitions for the write-queue serial transmitter:
// state encoding and frame geometry.
package write_queue_tx_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/write_queue_tx_baud_gen.sv
// Bit-period timer for the write-queue transmitter. The count restarts
// from zero whenever the FSM enters a new state, and wraps on its own
// between the data bits, so every bit lasts exactly CLKS_PER_BIT cycles.
module write_queue_tx_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Free-running modulo-CLKS_PER_BIT counter, cleared on reset or restart.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST_CNT) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bit_done = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/write_queue_tx.sv
// Write-queue serial transmitter: pops bytes from a first-word-fall-through
// queue and sends them LSB first as 8N1 frames on tx.
// Build option: define TX_PARITY_EN to insert an even-parity bit between
// D7 and STOP (frame grows from 10 to 11 bit periods).
// The pop decision is made one edge ahead so that pp_write, tx and busy can
// all come straight from flops: the pop cycle is a single IDLE cycle and the
// start bit follows on the next cycle.
module write_queue_tx
    import write_queue_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_write,
    input  logic                 em_write,
    output logic                 pp_write,
    output logic                 tx,
    output logic                 busy
);

    state_t               state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 pp_reg, pp_next;
    logic                 tx_reg, tx_next;
    logic                 busy_reg, busy_next;
    logic                 restart;
    logic                 bit_done;
`ifdef TX_PARITY_EN
    logic                 parity_reg, parity_next;
`endif

    write_queue_tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baud_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .bit_done(bit_done)
    );

    // State, datapath and registered-output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            idx_reg    <= '0;
            pp_reg     <= 1'b0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
`ifdef TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            idx_reg    <= idx_next;
            pp_reg     <= pp_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
`ifdef TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state logic, pop decision and next values of the registered outputs.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        pp_next    = 1'b0;
`ifdef TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pp_reg) begin
                    // Pop cycle in progress; byte already latched.
                    state_next = START;
                end else if (!em_write) begin
                    pp_next    = 1'b1;
                    shift_next = in_write;
`ifdef TX_PARITY_EN
                    parity_next = ^in_write;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
                    if (idx_reg == IDX_W'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                    // Decide the next pop now so it lands in the single IDLE cycle.
                    if (!em_write) begin
                        pp_next    = 1'b1;
                        shift_next = in_write;
`ifdef TX_PARITY_EN
                        parity_next = ^in_write;
`endif
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        restart = (state_next != state_reg);

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign pp_write = pp_reg;
    assign tx       = tx_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_write_queue_tx.sv
// Directed bench for write_queue_tx with CLKS_PER_BIT=4. A FWFT queue model
// feeds the DUT; each byte pushed also stores its expected frame, which is
// compared bit-period by bit-period when the DUT sends it.
// Honours TX_PARITY_EN the same way as the design.
module tb_write_queue_tx;

    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_write = 8'h00;
    logic       em_write = 1'b1;
    logic       pp_write;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    write_queue_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_write(in_write),
        .em_write(em_write),
        .pp_write(pp_write),
        .tx      (tx),
        .busy    (busy)
    );

    logic [7:0]            fifo_mem [0:63];
    logic [FRAME_BITS-1:0] exp_mem  [0:63];
    int                    pp_log   [0:63];
    int                    wr_ptr = 0;
    int                    rd_ptr = 0;
    int                    pend_q[$];
    int                    compared = 0;
    int                    mismatched = 0;
    int                    cyc = 0;
    int                    frames_done = 0;
    int                    pp_count = 0;
    int                    last_pp = -100;
    bit                    mon_active = 1'b0;
    int                    k = 0;
    logic [FRAME_BITS-1:0] cur_frame = '1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
        logic [FRAME_BITS-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    task automatic update_q();
        logic [5:0] ri;
        ri       = rd_ptr[5:0];
        em_write = (wr_ptr == rd_ptr);
        in_write = em_write ? 8'h00 : fifo_mem[ri];
    endtask

    task automatic push(input logic [7:0] b);
        logic [5:0] wi;
        wi           = wr_ptr[5:0];
        fifo_mem[wi] = b;
        exp_mem[wi]  = make_frame(b);
        wr_ptr++;
        update_q();
    endtask

    // One clock: sample on the falling edge, run the queue model and the frame monitor.
    task automatic tick();
        logic [5:0] idx;
        int         p;
        @(negedge clk);
        cyc++;
        if (rst) begin
            check("rst_tx", 32'(tx), 1);
            check("rst_busy", 32'(busy), 0);
            check("rst_pp", 32'(pp_write), 0);
            mon_active = 1'b0;
            pend_q.delete();
        end else begin
            if (pp_write === 1'b1) begin
                check("pop_nonempty", 32'(em_write), 0);
                check("pop_idle_busy", 32'(busy), 0);
                pend_q.push_back(rd_ptr);
                rd_ptr++;
                idx = pp_count[5:0];
                pp_log[idx] = cyc;
                pp_count++;
                last_pp = cyc;
            end
            if (mon_active) begin
                if (k < FRAME_CLKS) begin
                    check("frame_tx", 32'(tx), 32'(cur_frame[k / CPB]));
                    check("frame_busy", 32'(busy), 1);
                end else begin
                    check("gap_tx", 32'(tx), 1);
                    check("gap_busy", 32'(busy), 0);
                    mon_active = 1'b0;
                    frames_done++;
                end
                k++;
            end else if (tx === 1'b0) begin
                check("start_has_byte", 32'(pend_q.size() > 0), 1);
                check("pop_to_start", cyc - last_pp, 1);
                if (pend_q.size() > 0) begin
                    p = pend_q.pop_front();
                    idx = p[5:0];
                    cur_frame = exp_mem[idx];
                end
                check("frame_busy", 32'(busy), 1);
                mon_active = 1'b1;
                k = 1;
            end else begin
                check("idle_busy", 32'(busy), 0);
            end
        end
        update_q();
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        check("frame_timeout", 32'(frames_done >= target), 1);
    endtask

    initial begin
        int base;
        int pc;
        int n;
        logic [5:0] i0;
        logic [5:0] i1;

        // Reset held 3 cycles with a byte waiting.
        push(8'hA5);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("first_pp_after_rst", 32'(pp_write), 1);
        $display("step reset: first pop one cycle after release");

        // Single byte 0xA5.
        wait_frames(1, 100);
        check("a5_pop_count", pp_count, 1);
        $display("step 0xA5: frame %0d done, pops %0d", frames_done, pp_count);

        // Byte 0x07 (odd number of ones -> parity 1 when enabled).
        push(8'h07);
        wait_frames(2, 200);
        check("07_pop_count", pp_count, 2);
        $display("step 0x07: frame %0d done, pops %0d", frames_done, pp_count);

        // Back-to-back 0x00 then 0xFF from a pre-loaded queue.
        base = pp_count;
        push(8'h00);
        push(8'hFF);
        wait_frames(4, 300);
        i0 = base[5:0];
        i1 = i0 + 6'd1;
        check("b2b_pop_count", pp_count, base + 2);
        check("b2b_pop_gap", pp_log[i1] - pp_log[i0], FRAME_CLKS + 1);
        $display("step back-to-back: pop gap %0d", pp_log[i1] - pp_log[i0]);

        // Empty queue for 100 cycles.
        pc = pp_count;
        repeat (100) begin
            tick();
            check("empty_tx", 32'(tx), 1);
            check("empty_pp", 32'(pp_write), 0);
        end
        check("empty_pop_count", pp_count, pc);
        $display("step empty: 100 idle cycles, pops %0d", pp_count);

        // Reset during the third data bit of 0x55; 0x3C queued behind it.
        push(8'h55);
        push(8'h3C);
        n = 0;
        while (!(mon_active && k == 13) && n < 200) begin
            tick();
            n++;
        end
        check("reach_d2", 32'(mon_active && k == 13), 1);
        pc = pp_count;
        rst = 1'b1;
        tick();
        tick();
        check("rst_mid_tx", 32'(tx), 1);
        tick();
        tick();
        rst = 1'b0;
        base = frames_done;
        wait_frames(base + 1, 200);
        check("rst_no_refetch", pp_count, pc + 1);
        $display("step mid-frame reset: next byte sent, pops %0d", pp_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
